// File: rtl/lsu_rmw.sv
// Purpose : RV32 load/store unit in front of a word-wide, single-port data memory
//           without byte enables; sub-word stores are done as read-modify-write.
// Latency : load 3 cycles, SW 2, SB/SH 4, illegal/misaligned 1 (accept cycle = 0).
// Backpressure: one request at a time; req_ready only in IDLE and in the one-cycle
//           RESP state, so a new request can be taken in the done cycle.
//
// Ports:
//   clk, rst_n           single clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we/req_funct3    1 = store; RV32 funct3 (B/H/W/BU/HU)
//   req_addr/req_wdata   byte address, store data (low byte/halfword for B/H)
//   resp_done/resp_err   one-cycle completion pulse, error flag valid with it
//   resp_rdata           load result (0 for stores and errors)
//   mem_addr/mem_w_en/mem_w_data/mem_r_data  data memory port (registered outputs)
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/SH and W/SW return resp_err with no memory access
//   undefined : misaligned requests are silently aligned down to their natural size

module lsu_rmw #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_done,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [31:0]           mem_addr,
    output logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched request
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    // Output registers
    logic                  r_resp_done;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [31:0]           r_mem_addr;
    logic                  r_mem_w_en;
    logic [DATA_WIDTH-1:0] r_mem_w_data;

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_err;
    logic                  w_is_sw;
    logic [31:0]           w_acc_addr;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_accept = req_valid && req_ready;
    assign w_is_sw  = req_we && (req_funct3[1:0] == 2'b10);

    // Request decode: legality, misalignment policy and the address actually used.
    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_we;   // BU/HU exist only for loads
            default:                w_legal = 1'b0;
        endcase

        w_acc_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        w_err = !w_legal
              || ((req_funct3[1:0] == 2'b01) && req_addr[0])
              || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        w_err = !w_legal;
        if (req_funct3[1:0] == 2'b01) begin
            w_acc_addr[0] = 1'b0;
        end
        if (req_funct3[1:0] == 2'b10) begin
            w_acc_addr[1:0] = 2'b00;
        end
`endif
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        w_byte = mem_r_data[{r_lane, 3'b000} +: 8];
        w_half = mem_r_data[{r_lane[1], 4'b0000} +: 16];

        case (r_funct3)
            3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load = mem_r_data;
        endcase

        w_merged = mem_r_data;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and ready
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    if (w_err) begin
                        w_next = S_RESP;
                    end else if (w_is_sw) begin
                        w_next = S_WR;   // full word: no read needed
                    end else begin
                        w_next = S_RD;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD:    w_next = S_WAIT;
            S_WAIT:  w_next = r_we ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and output registers. The memory write is a single registered
    // pulse, so an asynchronous reset either lands before or after the write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_wdata      <= 16'h0000;
            r_resp_done  <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_w_en   <= 1'b0;
            r_mem_w_data <= '0;
        end else begin
            r_resp_done <= (w_next == S_RESP);
            r_resp_err  <= w_accept && w_err;

            if (w_accept) begin
                r_we         <= req_we;
                r_funct3     <= req_funct3;
                r_lane       <= w_acc_addr[1:0];
                r_wdata      <= req_wdata[15:0];
                r_resp_rdata <= '0;
                if (!w_err) begin
                    r_mem_addr <= w_acc_addr;
                    if (w_is_sw) begin
                        r_mem_w_en   <= 1'b1;
                        r_mem_w_data <= req_wdata;
                    end
                end
            end

            if (r_state == S_WAIT) begin
                if (r_we) begin
                    r_mem_w_en   <= 1'b1;
                    r_mem_w_data <= w_merged;
                end else begin
                    r_resp_rdata <= w_load;
                end
            end

            if (r_state == S_WR) begin
                r_mem_w_en <= 1'b0;
            end
        end
    end

    assign resp_done  = r_resp_done;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_w_en   = r_mem_w_en;
    assign mem_w_data = r_mem_w_data;

endmodule

// File: tb/tb_lsu_rmw.sv
// Purpose : scoreboard bench for lsu_rmw with a word-wide registered-read memory model.
// Latency : expected done/write cycles are hand-derived relative to the accept edge.
// Backpressure: the driver holds each request until req_ready is seen.

module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_done;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_w_en;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    always #5 clk = ~clk;

    lsu_rmw #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_done  (resp_done),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_w_en   (mem_w_en),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    // Memory model: one-cycle registered-address read, word write, backdoor preload.
    logic [31:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = 8'h0;
    logic [31:0] bd_data = 32'h0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_w_en) begin
            mem[mem_addr[9:2]] <= mem_w_data;
        end
        mem_r_data <= mem[mem_addr[9:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_wr_t;

    exp_resp_t q_resp[$];
    exp_wr_t   q_wr[$];
    exp_resp_t m_resp;
    exp_wr_t   m_wr;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_tot++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a done or a write.
    always @(negedge clk) begin
        if (resp_done) begin
            if (q_resp.size() == 0) begin
                fail("unexpected_resp_done");
            end else begin
                m_resp = q_resp.pop_front();
                chk("done_cycle", cyc, m_resp.cyc);
                chk("resp_err", {31'b0, resp_err}, {31'b0, m_resp.err});
                chk("resp_rdata", resp_rdata, m_resp.rdata);
            end
        end
        if (mem_w_en) begin
            if (q_wr.size() == 0) begin
                fail("unexpected_mem_w_en");
            end else begin
                m_wr = q_wr.pop_front();
                chk("wr_cycle", cyc, m_wr.cyc);
                chk("wr_addr", {mem_addr[31:2], 2'b00}, m_wr.addr);
                chk("wr_data", mem_w_data, m_wr.data);
            end
        end
    end

    // Drive one request and return the cycle index of its accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int k);
        int t;
        t = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) fail("req_ready_timeout");
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        k = cyc;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp_rd, input logic exp_err, output int k);
        issue(1'b0, f3, a, 32'h0, k);
        q_resp.push_back('{exp_err, exp_rd, k + (exp_err ? 1 : 3)});
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] wa, input logic [31:0] wv,
                         output int k);
        issue(1'b1, f3, a, wd, k);
        if (exp_err) begin
            q_resp.push_back('{1'b1, 32'h0, k + 1});
        end else if (f3 == 3'b010) begin
            q_wr.push_back('{wa, wv, k + 1});
            q_resp.push_back('{1'b0, 32'h0, k + 2});
        end else begin
            q_wr.push_back('{wa, wv, k + 3});
            q_resp.push_back('{1'b0, 32'h0, k + 4});
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while ((q_resp.size() != 0 || q_wr.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("resp_queue_empty", q_resp.size(), 32'd0);
        chk("wr_queue_empty", q_wr.size(), 32'd0);
    endtask

    logic [31:0] word100;

    initial begin
        int k;
        int k_sw;
        int k_lw;

        #2 rst_n = 1'b0;
        bd_we   = 1'b1;
        bd_idx  = 8'd64;              // 0x100
        bd_data = 32'h8899_AABB;
        @(posedge clk);
        #1 bd_we = 1'b0;

        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_done", {31'b0, resp_done}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_w_en", {31'b0, mem_w_en}, 32'd0);
        chk("rst_mem_w_data", mem_w_data, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Loads from 0x100 = 0x8899AABB
        load(3'b000, 32'h101, 32'hFFFF_FFAA, 1'b0, k);   // LB
        load(3'b100, 32'h101, 32'h0000_00AA, 1'b0, k);   // LBU
        load(3'b101, 32'h102, 32'h0000_8899, 1'b0, k);   // LHU
        load(3'b001, 32'h102, 32'hFFFF_8899, 1'b0, k);   // LH
        load(3'b000, 32'h100, 32'hFFFF_FFBB, 1'b0, k);   // LB lane 0
        load(3'b000, 32'h103, 32'hFFFF_FF88, 1'b0, k);   // LB lane 3
        load(3'b100, 32'h102, 32'h0000_0099, 1'b0, k);   // LBU lane 2
        load(3'b001, 32'h100, 32'hFFFF_AABB, 1'b0, k);   // LH lane 0
        load(3'b010, 32'h100, 32'h8899_AABB, 1'b0, k);   // LW

        // SB lane 2, then read back
        store(3'b000, 32'h102, 32'h1234_5611, 1'b0, 32'h100, 32'h8811_AABB, k);
        load(3'b010, 32'h100, 32'h8811_AABB, 1'b0, k);

        // SW followed back-to-back by LW in the SW done cycle
        store(3'b010, 32'h104, 32'hDEAD_BEEF, 1'b0, 32'h104, 32'hDEAD_BEEF, k_sw);
        load(3'b010, 32'h104, 32'hDEAD_BEEF, 1'b0, k_lw);
        chk("b2b_accept_cycle", k_lw, k_sw + 2);

        // Misaligned SH at 0x103
`ifdef LSU_MISALIGN_TRAP_EN
        store(3'b001, 32'h103, 32'h0000_CAFE, 1'b1, 32'h0, 32'h0, k);
        word100 = 32'h8811_AABB;
`else
        store(3'b001, 32'h103, 32'h0000_CAFE, 1'b0, 32'h100, 32'hCAFE_AABB, k);
        word100 = 32'hCAFE_AABB;
`endif
        load(3'b010, 32'h100, word100, 1'b0, k);

        // Illegal encodings
        load(3'b011, 32'h100, 32'h0, 1'b1, k);
        load(3'b110, 32'h100, 32'h0, 1'b1, k);
        store(3'b100, 32'h100, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, k);
        store(3'b111, 32'h100, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, k);
        drain();

        // SB interrupted by reset in cycle 2: no write and no done
        issue(1'b1, 3'b000, 32'h100, 32'h0000_0077, k);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_w_en", {31'b0, mem_w_en}, 32'd0);
        chk("abort_resp_done", {31'b0, resp_done}, 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        load(3'b010, 32'h100, word100, 1'b0, k);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
